mfp_eic_ctrl: RTL and testbench



---
 rtl/mfp_eic_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mfp_eic_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_eic_ctrl.sv
// External interrupt controller for the microAptiv EIC-mode inputs: latches channel requests,
// applies mask/priority, offers the winner to the core and retires it on SI_IAck.
// Define MFP_EIC_SYNC_EN to pass irq_req through a 2-flop synchronizer before edge/level logic.
module mfp_eic_ctrl #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned PRIO_W      = 3,
  parameter logic [16:0] OFFSET_BASE = 17'h100,
  parameter logic [16:0] OFFSET_STEP = 17'h10
) (
  input  logic                SI_ClkIn,
  input  logic                SI_ColdReset,
  input  logic [CHANNELS-1:0] irq_req,
  input  logic                reg_we,
  input  logic [4:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  input  logic                SI_IAck,
  input  logic [7:0]          SI_IPL,
  output logic [7:0]          eic_ripl,
  output logic [5:0]          eic_vector,
  output logic [16:0]         eic_offset,
  output logic [3:0]          eic_eiss,
  output logic                eic_busy
);

  typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] edge_q, edge_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] req_q, req_d;
  logic [PRIO_W-1:0]   prio_q [CHANNELS];
  logic [PRIO_W-1:0]   prio_d [CHANNELS];
  logic [7:0]          ripl_q, ripl_d;
  logic [5:0]          vector_q, vector_d;
  logic [16:0]         offset_q, offset_d;
  logic                busy_q, busy_d;

  logic [CHANNELS-1:0] req_in;
  logic [CHANNELS-1:0] w1c;
  logic [CHANNELS-1:0] ack_clr;
  logic [CHANNELS-1:0] cand;
  logic                cur_cand;
  logic                win_valid;
  logic [PRIO_W-1:0]   win_prio;
  logic [5:0]          win_idx;
  logic [7:0]          win_ripl;
  logic [16:0]         win_off;
  logic                unused_wdata;

  assign unused_wdata = ^reg_wdata;

`ifdef MFP_EIC_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_req;
    sync2_d = sync1_q;
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_ColdReset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign req_in = sync2_q;
`else
  assign req_in = irq_req;
`endif

  // Register writes, pending update (edge set wins over ACK/W1C clear; level tracks the input)
  always_comb begin
    mask_d  = mask_q;
    edge_d  = edge_q;
    prio_d  = prio_q;
    w1c     = '0;
    ack_clr = '0;
    req_d   = req_in;
    if (reg_we) begin
      case (reg_addr)
        5'd0: mask_d = reg_wdata[CHANNELS-1:0];
        5'd1: edge_d = reg_wdata[CHANNELS-1:0];
        5'd2: w1c    = reg_wdata[CHANNELS-1:0];
        default: begin
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(reg_addr) == i + 32'd8) prio_d[i] = reg_wdata[PRIO_W-1:0];
          end
        end
      endcase
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      ack_clr[i] = (state_q == OFFER) && SI_IAck && (vector_q == 6'(i));
    end
    pend_d = (edge_q & ((pend_q & ~(ack_clr | w1c)) | (req_in & ~req_q)))
           | (~edge_q & req_in);
  end

  // Winner: highest priority, lowest index on ties (strict compare while scanning upward)
  always_comb begin
    win_valid = 1'b0;
    win_prio  = '0;
    win_idx   = '0;
    cur_cand  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand[i] = pend_q[i] & ~mask_q[i] & (prio_q[i] != '0);
      if (cand[i] && (prio_q[i] > win_prio)) begin
        win_valid = 1'b1;
        win_prio  = prio_q[i];
        win_idx   = 6'(i);
      end
      if (vector_q == 6'(i)) cur_cand = cand[i];
    end
    win_ripl = 8'(win_prio);
    win_off  = OFFSET_BASE + OFFSET_STEP * 17'(win_idx);
  end

  always_comb begin
    state_d  = state_q;
    ripl_d   = ripl_q;
    vector_d = vector_q;
    offset_d = offset_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d  = OFFER;
          ripl_d   = win_ripl;
          vector_d = win_idx;
          offset_d = win_off;
          busy_d   = 1'b1;
        end
      end
      OFFER: begin
        if (SI_IAck) begin
          state_d = ACK;
          ripl_d  = '0;
        end else if (!cur_cand) begin
          state_d  = IDLE;
          ripl_d   = '0;
          vector_d = '0;
          offset_d = OFFSET_BASE;
          busy_d   = 1'b0;
        end else if (win_valid && (win_ripl > ripl_q)) begin
          ripl_d   = win_ripl;
          vector_d = win_idx;
          offset_d = win_off;
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ripl_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_ColdReset) begin
      state_q  <= IDLE;
      mask_q   <= '1;
      edge_q   <= '0;
      pend_q   <= '0;
      req_q    <= '0;
      ripl_q   <= '0;
      vector_q <= '0;
      offset_q <= OFFSET_BASE;
      busy_q   <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) prio_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      ripl_q   <= ripl_d;
      vector_q <= vector_d;
      offset_q <= offset_d;
      busy_q   <= busy_d;
      prio_q   <= prio_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      5'd0: reg_rdata[CHANNELS-1:0] = mask_q;
      5'd1: reg_rdata[CHANNELS-1:0] = edge_q;
      5'd2: reg_rdata[CHANNELS-1:0] = pend_q;
      5'd3: reg_rdata = {16'b0, SI_IPL, 2'b0, vector_q};
      default: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (32'(reg_addr) == i + 32'd8) reg_rdata[PRIO_W-1:0] = prio_q[i];
        end
      end
    endcase
  end

  assign eic_ripl   = ripl_q;
  assign eic_vector = vector_q;
  assign eic_offset = offset_q;
  assign eic_eiss   = '0;
  assign eic_busy   = busy_q;

endmodule

// File: tb/tb_mfp_eic_ctrl.sv
// Self-checking bench for mfp_eic_ctrl: directed scenarios plus randomized traffic against
// a behavioural model of the controller (8 channels, 3-bit priority, default offsets).
module tb_mfp_eic_ctrl;

`ifdef MFP_EIC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        SI_ColdReset;
  logic [7:0]  irq_req;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        SI_IAck;
  logic [7:0]  SI_IPL;
  logic [7:0]  eic_ripl;
  logic [5:0]  eic_vector;
  logic [16:0] eic_offset;
  logic [3:0]  eic_eiss;
  logic        eic_busy;

  int n_vec = 0;
  int n_err = 0;

  mfp_eic_ctrl #(
    .CHANNELS(8),
    .PRIO_W(3),
    .OFFSET_BASE(17'h100),
    .OFFSET_STEP(17'h10)
  ) dut (
    .SI_ClkIn(clk),
    .SI_ColdReset(SI_ColdReset),
    .irq_req(irq_req),
    .reg_we(reg_we),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .SI_IAck(SI_IAck),
    .SI_IPL(SI_IPL),
    .eic_ripl(eic_ripl),
    .eic_vector(eic_vector),
    .eic_offset(eic_offset),
    .eic_eiss(eic_eiss),
    .eic_busy(eic_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: m_state 0 = nothing offered, 1 = offering, 2 = acknowledge cycle
  logic [7:0]  m_mask, m_edge, m_pend, m_req, m_d1, m_d2;
  int          m_prio [8];
  int          m_state;
  logic [7:0]  m_ripl;
  logic [5:0]  m_vec;
  logic [16:0] m_off;
  logic        m_busy;

  function automatic bit m_cand(int i);
    return m_pend[i] && !m_mask[i] && (m_prio[i] != 0);
  endfunction

  function automatic int m_winner();
    for (int p = 7; p >= 1; p--)
      for (int i = 0; i < 8; i++)
        if (m_cand(i) && m_prio[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd0: return {24'b0, m_mask};
      5'd1: return {24'b0, m_edge};
      5'd2: return {24'b0, m_pend};
      5'd3: return {16'b0, SI_IPL, 2'b0, m_vec};
      default: if (a >= 5'd8 && a < 5'd16) return 32'(m_prio[int'(a) - 8]);
    endcase
    return 32'd0;
  endfunction

  task automatic m_present(input int w);
    m_state = 1;
    m_ripl  = 8'(m_prio[w]);
    m_vec   = 6'(w);
    m_off   = 17'h100 + 17'(w) * 17'h10;
    m_busy  = 1'b1;
  endtask

  task automatic model_step();
    logic [7:0] eff, npend;
    int w;
    if (SI_ColdReset) begin
      m_mask = 8'hFF; m_edge = '0; m_pend = '0; m_req = '0; m_d1 = '0; m_d2 = '0;
      for (int i = 0; i < 8; i++) m_prio[i] = 0;
      m_state = 0; m_ripl = '0; m_vec = '0; m_off = 17'h100; m_busy = 1'b0;
      return;
    end
`ifdef MFP_EIC_SYNC_EN
    eff = m_d2; m_d2 = m_d1; m_d1 = irq_req;
`else
    eff = irq_req;
`endif
    w = m_winner();
    for (int i = 0; i < 8; i++) begin
      if (!m_edge[i]) npend[i] = eff[i];
      else if (eff[i] && !m_req[i]) npend[i] = 1'b1;
      else begin
        npend[i] = m_pend[i];
        if (m_state == 1 && SI_IAck && int'(m_vec) == i) npend[i] = 1'b0;
        if (reg_we && reg_addr == 5'd2 && reg_wdata[i]) npend[i] = 1'b0;
      end
    end
    case (m_state)
      0: if (w >= 0) m_present(w);
      1: begin
        if (SI_IAck) begin
          m_state = 2; m_ripl = '0;
        end else if (!m_cand(int'(m_vec))) begin
          m_state = 0; m_ripl = '0; m_vec = '0; m_off = 17'h100; m_busy = 1'b0;
        end else if (w >= 0 && m_prio[w] > int'(m_ripl)) m_present(w);
      end
      default: begin m_state = 0; m_busy = 1'b0; end
    endcase
    if (reg_we) begin
      if (reg_addr == 5'd0) m_mask = reg_wdata[7:0];
      else if (reg_addr == 5'd1) m_edge = reg_wdata[7:0];
      else if (reg_addr >= 5'd8 && reg_addr < 5'd16) m_prio[int'(reg_addr) - 8] = int'(reg_wdata[2:0]);
    end
    m_pend = npend;
    m_req  = eff;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic do_reset();
    irq_req = '0; SI_IAck = 1'b0; reg_we = 1'b0;
    SI_ColdReset = 1'b1;
    tick();
    SI_ColdReset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    SI_IPL = 8'hA5;
    n_vec++; if (eic_ripl !== 8'd0) begin n_err++; $display("FAIL rst_ripl got %h want 00", eic_ripl); end
    n_vec++; if (eic_vector !== 6'd0) begin n_err++; $display("FAIL rst_vec got %h want 00", eic_vector); end
    n_vec++; if (eic_offset !== 17'h100) begin n_err++; $display("FAIL rst_off got %h want 00100", eic_offset); end
    n_vec++; if (eic_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", eic_busy); end
    n_vec++; if (eic_eiss !== 4'd0) begin n_err++; $display("FAIL rst_eiss got %h want 0", eic_eiss); end
    reg_addr = 5'd0; #1;
    n_vec++; if (reg_rdata !== 32'hFF) begin n_err++; $display("FAIL rst_mask got %h want 000000ff", reg_rdata); end
    reg_addr = 5'd1; #1;
    n_vec++; if (reg_rdata !== 32'h0) begin n_err++; $display("FAIL rst_edge got %h want 0", reg_rdata); end
    reg_addr = 5'd2; #1;
    n_vec++; if (reg_rdata !== 32'h0) begin n_err++; $display("FAIL rst_pend got %h want 0", reg_rdata); end
    reg_addr = 5'd3; #1;
    n_vec++; if (reg_rdata !== 32'h0000A500) begin n_err++; $display("FAIL rst_status got %h want 0000a500", reg_rdata); end
    for (int a = 8; a < 16; a++) begin
      reg_addr = 5'(a); #1;
      n_vec++; if (reg_rdata !== 32'h0) begin n_err++; $display("FAIL rst_prio%0d got %h want 0", a - 8, reg_rdata); end
    end
    reg_addr = 5'd31; #1;
    n_vec++; if (reg_rdata !== 32'h0) begin n_err++; $display("FAIL rst_unmapped got %h want 0", reg_rdata); end
  endtask

  task automatic test_edge_ack();
    do_reset();
    wr(5'd0, 32'h0); wr(5'd11, 32'd5); wr(5'd1, 32'h08);
    irq_req[3] = 1'b1; tick(); irq_req = '0;
    repeat (LAT - 2) tick();
    n_vec++; if (eic_ripl !== 8'd0) begin n_err++; $display("FAIL edge_early got %0d want 0", eic_ripl); end
    tick();
    n_vec++; if (eic_ripl !== 8'd5) begin n_err++; $display("FAIL edge_ripl got %0d want 5", eic_ripl); end
    n_vec++; if (eic_vector !== 6'd3) begin n_err++; $display("FAIL edge_vec got %0d want 3", eic_vector); end
    n_vec++; if (eic_offset !== 17'h130) begin n_err++; $display("FAIL edge_off got %h want 00130", eic_offset); end
    n_vec++; if (eic_busy !== 1'b1) begin n_err++; $display("FAIL edge_busy got %b want 1", eic_busy); end
    SI_IAck = 1'b1; tick(); SI_IAck = 1'b0;
    n_vec++; if (eic_ripl !== 8'd0) begin n_err++; $display("FAIL ack_ripl got %0d want 0", eic_ripl); end
    n_vec++; if (eic_busy !== 1'b1) begin n_err++; $display("FAIL ack_busy got %b want 1", eic_busy); end
    reg_addr = 5'd2; #1;
    n_vec++; if (reg_rdata !== 32'h0) begin n_err++; $display("FAIL ack_pend got %h want 0", reg_rdata); end
    tick(); tick();
    n_vec++; if (eic_ripl !== 8'd0 || eic_busy !== 1'b0) begin n_err++; $display("FAIL ack_after got ripl=%0d busy=%b want 0/0", eic_ripl, eic_busy); end
  endtask

  task automatic test_prio_preempt();
    do_reset();
    wr(5'd0, 32'h0); wr(5'd9, 32'd4); wr(5'd14, 32'd4);
    irq_req = 8'h42;
    repeat (LAT) tick();
    n_vec++; if (eic_vector !== 6'd1 || eic_ripl !== 8'd4) begin n_err++; $display("FAIL tie_low got vec=%0d ripl=%0d want 1/4", eic_vector, eic_ripl); end
    wr(5'd14, 32'd7);
    tick();
    n_vec++; if (eic_vector !== 6'd6 || eic_ripl !== 8'd7) begin n_err++; $display("FAIL preempt got vec=%0d ripl=%0d want 6/7", eic_vector, eic_ripl); end
    n_vec++; if (eic_offset !== 17'h160) begin n_err++; $display("FAIL preempt_off got %h want 00160", eic_offset); end
    irq_req = '0;
    repeat (LAT) tick();
    n_vec++; if (eic_ripl !== 8'd0 || eic_busy !== 1'b0) begin n_err++; $display("FAIL preempt_drop got ripl=%0d busy=%b want 0/0", eic_ripl, eic_busy); end
  endtask

  task automatic test_ack_set_race();
    do_reset();
    wr(5'd0, 32'h0); wr(5'd1, 32'h04); wr(5'd10, 32'd3);
    irq_req[2] = 1'b1; tick(); irq_req = '0;
    repeat (LAT) tick();
    n_vec++; if (eic_vector !== 6'd2 || eic_ripl !== 8'd3) begin n_err++; $display("FAIL race_offer got vec=%0d ripl=%0d want 2/3", eic_vector, eic_ripl); end
    irq_req[2] = 1'b1;
    repeat (LAT - 2) tick();
    SI_IAck = 1'b1; tick(); SI_IAck = 1'b0; irq_req = '0;
    reg_addr = 5'd2; #1;
    n_vec++; if (reg_rdata !== 32'h04) begin n_err++; $display("FAIL race_pend got %h want 00000004", reg_rdata); end
    n_vec++; if (eic_ripl !== 8'd0) begin n_err++; $display("FAIL race_ack got %0d want 0", eic_ripl); end
    tick();
    n_vec++; if (eic_busy !== 1'b0) begin n_err++; $display("FAIL race_idle got %b want 0", eic_busy); end
    tick();
    n_vec++; if (eic_vector !== 6'd2 || eic_ripl !== 8'd3) begin n_err++; $display("FAIL race_repres got vec=%0d ripl=%0d want 2/3", eic_vector, eic_ripl); end
    SI_IAck = 1'b1; tick(); SI_IAck = 1'b0;
    reg_addr = 5'd2; #1;
    n_vec++; if (reg_rdata !== 32'h0) begin n_err++; $display("FAIL race_clr got %h want 0", reg_rdata); end
  endtask

  task automatic test_level_drop();
    do_reset();
    wr(5'd0, 32'h0); wr(5'd8, 32'd6);
    irq_req[0] = 1'b1;
    repeat (LAT) tick();
    n_vec++; if (eic_ripl !== 8'd6 || eic_vector !== 6'd0) begin n_err++; $display("FAIL lvl_offer got ripl=%0d vec=%0d want 6/0", eic_ripl, eic_vector); end
    wr(5'd2, 32'h1);
    reg_addr = 5'd2; #1;
    n_vec++; if (reg_rdata !== 32'h1) begin n_err++; $display("FAIL lvl_w1c got %h want 00000001", reg_rdata); end
    n_vec++; if (eic_ripl !== 8'd6) begin n_err++; $display("FAIL lvl_w1c_ripl got %0d want 6", eic_ripl); end
    irq_req[0] = 1'b0;
    repeat (LAT - 1) tick();
    n_vec++; if (eic_ripl !== 8'd6) begin n_err++; $display("FAIL lvl_hold got %0d want 6", eic_ripl); end
    tick();
    n_vec++; if (eic_ripl !== 8'd0 || eic_busy !== 1'b0) begin n_err++; $display("FAIL lvl_drop got ripl=%0d busy=%b want 0/0", eic_ripl, eic_busy); end
  endtask

  task automatic test_mask_reset();
    do_reset();
    wr(5'd13, 32'd2);
    irq_req = 8'h22;
    repeat (LAT + 2) tick();
    n_vec++; if (eic_ripl !== 8'd0) begin n_err++; $display("FAIL masked got %0d want 0", eic_ripl); end
    wr(5'd0, 32'hDF);
    tick();
    n_vec++; if (eic_ripl !== 8'd2 || eic_vector !== 6'd5) begin n_err++; $display("FAIL unmask got ripl=%0d vec=%0d want 2/5", eic_ripl, eic_vector); end
    n_vec++; if (eic_offset !== 17'h150) begin n_err++; $display("FAIL unmask_off got %h want 00150", eic_offset); end
    SI_ColdReset = 1'b1; tick(); SI_ColdReset = 1'b0;
    n_vec++; if (eic_ripl !== 8'd0 || eic_vector !== 6'd0 || eic_busy !== 1'b0 || eic_offset !== 17'h100)
      begin n_err++; $display("FAIL midrst got ripl=%0d vec=%0d busy=%b off=%h want 0/0/0/00100", eic_ripl, eic_vector, eic_busy, eic_offset); end
    reg_addr = 5'd0; #1;
    n_vec++; if (reg_rdata !== 32'hFF) begin n_err++; $display("FAIL midrst_mask got %h want 000000ff", reg_rdata); end
    irq_req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      SI_ColdReset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) irq_req = irq_req ^ (8'h01 << $urandom_range(0, 7));
      SI_IAck = ($urandom_range(0, 3) == 0);
      SI_IPL  = 8'($urandom);
      reg_we  = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 7))
        0: reg_addr = 5'd0;
        1: reg_addr = 5'd1;
        2: reg_addr = 5'd2;
        3: reg_addr = 5'd3;
        4, 5: reg_addr = 5'(8 + $urandom_range(0, 7));
        default: reg_addr = 5'($urandom_range(0, 31));
      endcase
      reg_wdata = $urandom;
      if (reg_addr == 5'd0) reg_wdata = $urandom & $urandom;
      #1;
      n_vec++; if (reg_rdata !== m_rdata(reg_addr))
        begin n_err++; $display("FAIL rnd_rdata cyc %0d addr %0d got %h want %h", c, reg_addr, reg_rdata, m_rdata(reg_addr)); end
      tick();
      n_vec++; if (eic_ripl !== m_ripl) begin n_err++; $display("FAIL rnd_ripl cyc %0d got %0d want %0d", c, eic_ripl, m_ripl); end
      n_vec++; if (eic_vector !== m_vec) begin n_err++; $display("FAIL rnd_vec cyc %0d got %0d want %0d", c, eic_vector, m_vec); end
      n_vec++; if (eic_offset !== m_off) begin n_err++; $display("FAIL rnd_off cyc %0d got %h want %h", c, eic_offset, m_off); end
      n_vec++; if (eic_busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, eic_busy, m_busy); end
      n_vec++; if (eic_eiss !== 4'd0) begin n_err++; $display("FAIL rnd_eiss cyc %0d got %h want 0", c, eic_eiss); end
    end
    SI_ColdReset = 1'b0; SI_IAck = 1'b0; reg_we = 1'b0; irq_req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    SI_ColdReset = 1'b1; irq_req = '0; reg_we = 1'b0; reg_addr = '0;
    reg_wdata = '0; SI_IAck = 1'b0; SI_IPL = '0;
    test_reset();
    test_edge_ack();
    test_prio_preempt();
    test_ack_set_race();
    test_level_drop();
    test_mask_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
